// File: rtl/rr_word_arbiter_mux.sv
// Registered N-channel word multiplexer with round-robin or fixed-priority
// arbitration, packet locking and valid/ready handshakes on both sides.
module rr_word_arbiter_mux #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = 0,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_last
);

  typedef enum logic {ARB, LOCK} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_q, lock_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   chan_q, chan_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               grant_last;
  logic               accept;
  logic               xfer;

  // Grant selection: locked channel, lowest index, or rotating search after ptr.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == LOCK) begin
      grant_vld = in_valid[lock_q];
      grant_idx = lock_q;
    end else if (MODE == 1) begin
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Farthest candidate first so the nearest one after ptr wins last.
      for (int k = int'(CHANNELS); k >= 1; k--) begin
        cand = 32'(ptr_q) + 32'(k);
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        if (in_valid[SEL_W'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end
  end

  // Word and last-flag of the granted channel.
  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        grant_last = in_last[i];
      end
    end
  end

  assign accept = ~valid_q | out_ready;
  assign xfer   = grant_vld & accept & rst_n;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      in_ready[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  // Next-state and output-register update.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      chan_d  = grant_idx;
      last_d  = grant_last;
      if (MODE == 0) ptr_d = grant_idx;
      case (state_q)
        ARB: begin
          if (!grant_last) begin
            state_d = LOCK;
            lock_d  = grant_idx;
          end
        end
        LOCK: begin
          if (grant_last) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      lock_q  <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_rr_word_arbiter_mux.sv
// Directed bench for rr_word_arbiter_mux: a round-robin and a fixed-priority
// instance share all inputs; each scenario task checks its own expectations.
module tb_rr_word_arbiter_mux;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rdy0, rdy1;
  logic           ov0, ov1, ol0, ol1;
  logic [W-1:0]   od0, od1;
  logic [1:0]     oc0, oc1;
  logic [35:0]    obs0, obs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs0 = {ov0, oc0, ol0, od0};
  assign obs1 = {ov1, oc1, ol1, od1};

  rr_word_arbiter_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_chan(oc0), .out_last(ol0)
  );

  rr_word_arbiter_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_chan(oc1), .out_last(ol1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_data   = '0;
    in_last   = '1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #2;
    checks++;
    if (obs0 !== 36'h0) begin
      errors++;
      $display("FAIL reset_out: got %h exp %h", obs0, 36'h0);
    end
    checks++;
    if (rdy0 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b exp %b", rdy0, 4'b0000);
    end
    tick();
    checks++;
    if (obs0 !== 36'h0) begin
      errors++;
      $display("FAIL reset_hold_edge: got %h exp %h", obs0, 36'h0);
    end
    in_valid = '0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    set_word(2, 32'hA5A5_0001);
    in_valid  = 4'b0100;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b exp %b", rdy0, 4'b0100);
    end
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd2, 1'b1, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL single_out: got %h exp %h", obs0, {1'b1, 2'd2, 1'b1, 32'hA5A5_0001});
    end
    in_valid = '0;
    tick();
    checks++;
    if (obs0 !== {1'b0, 2'd2, 1'b1, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL single_drain: got %h exp %h", obs0, {1'b0, 2'd2, 1'b1, 32'hA5A5_0001});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < int'(N); i++) set_word(i, 32'h100 + 32'(i));
    in_last  = 4'b1111;
    in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs0 !== {1'b1, 2'(c % 4), 1'b1, 32'h100 + 32'(c % 4)}) begin
        errors++;
        $display("FAIL rr_cycle%0d: got %h exp %h", c, obs0,
                 {1'b1, 2'(c % 4), 1'b1, 32'h100 + 32'(c % 4)});
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_word(1, 32'h11);
    set_word(3, 32'h33);
    in_last  = 4'b1111;
    in_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rdy1 !== 4'b0010) begin
        errors++;
        $display("FAIL fp_ready%0d: got %b exp %b", c, rdy1, 4'b0010);
      end
      tick();
      checks++;
      if (obs1 !== {1'b1, 2'd1, 1'b1, 32'h11}) begin
        errors++;
        $display("FAIL fp_out%0d: got %h exp %h", c, obs1, {1'b1, 2'd1, 1'b1, 32'h11});
      end
    end
    in_valid = 4'b1000;
    #1;
    checks++;
    if (rdy1 !== 4'b1000) begin
      errors++;
      $display("FAIL fp_drop_ready: got %b exp %b", rdy1, 4'b1000);
    end
    tick();
    checks++;
    if (obs1 !== {1'b1, 2'd3, 1'b1, 32'h33}) begin
      errors++;
      $display("FAIL fp_drop_out: got %h exp %h", obs1, {1'b1, 2'd3, 1'b1, 32'h33});
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_word(0, 32'h1234_5678);
    in_last  = 4'b1111;
    in_valid = 4'b0001;
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL bp_load: got %h exp %h", obs0, {1'b1, 2'd0, 1'b1, 32'h1234_5678});
    end
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_word(1, 32'hDEAD_0001);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rdy0 !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b exp %b", c, rdy0, 4'b0000);
      end
      tick();
      checks++;
      if (obs0 !== {1'b1, 2'd0, 1'b1, 32'h1234_5678}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h exp %h", c, obs0, {1'b1, 2'd0, 1'b1, 32'h1234_5678});
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready: got %b exp %b", rdy0, 4'b0010);
    end
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd1, 1'b1, 32'hDEAD_0001}) begin
      errors++;
      $display("FAIL bp_refill: got %h exp %h", obs0, {1'b1, 2'd1, 1'b1, 32'hDEAD_0001});
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_packet_lock();
    logic [N-1:0]  vld_v  [5];
    logic [W-1:0]  d0_v   [5];
    logic          l0_v   [5];
    logic [N-1:0]  rdy_e  [5];
    logic [35:0]   out_e  [5];
    vld_v = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
    d0_v  = '{32'hC1, 32'hC2, 32'hC2, 32'hC3, 32'hC3};
    l0_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rdy_e = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0010};
    out_e = '{{1'b1, 2'd0, 1'b0, 32'hC1}, {1'b1, 2'd0, 1'b0, 32'hC2},
              {1'b0, 2'd0, 1'b0, 32'hC2}, {1'b1, 2'd0, 1'b1, 32'hC3},
              {1'b1, 2'd1, 1'b1, 32'hB1}};
    do_reset();
    set_word(1, 32'hB1);
    for (int c = 0; c < 5; c++) begin
      in_valid = vld_v[c];
      in_last  = {2'b00, 1'b1, l0_v[c]};
      set_word(0, d0_v[c]);
      #1;
      checks++;
      if (rdy0 !== rdy_e[c]) begin
        errors++;
        $display("FAIL lock_ready%0d: got %b exp %b", c, rdy0, rdy_e[c]);
      end
      tick();
      checks++;
      if (obs0 !== out_e[c]) begin
        errors++;
        $display("FAIL lock_out%0d: got %h exp %h", c, obs0, out_e[c]);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_word(0, 32'hE0);
    set_word(1, 32'hE1);
    in_last  = 4'b0000;
    in_valid = 4'b0001;
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b0, 32'hE0}) begin
      errors++;
      $display("FAIL rmid_load: got %h exp %h", obs0, {1'b1, 2'd0, 1'b0, 32'hE0});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 36'h0) begin
      errors++;
      $display("FAIL rmid_async_out: got %h exp %h", obs0, 36'h0);
    end
    checks++;
    if (rdy0 !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_ready: got %b exp %b", rdy0, 4'b0000);
    end
    rst_n    = 1'b1;
    in_last  = 4'b1111;
    in_valid = 4'b0011;
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd0, 1'b1, 32'hE0}) begin
      errors++;
      $display("FAIL rmid_first: got %h exp %h", obs0, {1'b1, 2'd0, 1'b1, 32'hE0});
    end
    tick();
    checks++;
    if (obs0 !== {1'b1, 2'd1, 1'b1, 32'hE1}) begin
      errors++;
      $display("FAIL rmid_second: got %h exp %h", obs0, {1'b1, 2'd1, 1'b1, 32'hE1});
    end
    in_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_packet_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_word_arbiter_mux.md
# rr_word_arbiter_mux

Parametrised, registered N-channel word multiplexer with built-in arbitration and valid/ready handshakes. It selects one of CHANNELS requesters, which can be bus masters or ALU/memory result sources. Channels are chosen by round-robin or fixed priority and may hold the grant across multi-word packets. The selected word passes through one output register stage. It is the sequential, arbitrated successor to the combinational word/tree muxes and sits in front of shared datapath resources of the 32-bit machine.

## Interface
- WIDTH, 32, data word width in bits (1..64).
- CHANNELS, 4, number of input channels (2..32).
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_W, derived = max(1, clog2(CHANNELS)), width of channel index; not overridden.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  CHANNELS  per-channel word valid.
- in_ready  output  CHANNELS  per-channel accept; at most one bit high.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  CHANNELS  per-channel end-of-packet marker.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered word.
- out_chan  output  SEL_W  source channel of out_data.
- out_last  output  1  registered in_last of that word.

## Operation
- State machine has 2 states: ARB and LOCK. A register lock_chan is used in LOCK. A register ptr holds the last granted channel in round-robin mode.
- Grant computation is combinational:
  - In ARB, MODE 0: the first valid channel searching ptr+1, ptr+2, … with wrap modulo CHANNELS.
  - In ARB, MODE 1: the lowest-index valid channel.
  - In LOCK: lock_chan only, regardless of other valids.
  - No grant if no candidate channel is valid.
- in_ready[g] = grant[g] & (~out_valid | out_ready). All other in_ready bits are 0. in_ready may depend on in_valid. in_valid must not depend on in_ready.
- Transfer occurs on channel g when in_valid[g] & in_ready[g]. On a transfer:
  - out_data ← word g, out_chan ← g, out_last ← in_last[g], out_valid ← 1.
  - MODE 0: ptr ← g.
  - ARB with in_last[g]=0 → LOCK, lock_chan ← g.
  - LOCK with in_last[g]=1 → ARB.
  - ARB with in_last=1 stays in ARB. LOCK with in_last=0 stays in LOCK.
- If there is no transfer and out_ready=1, out_valid ← 0. out_data, out_chan and out_last hold their last values.
- While out_valid=1 and out_ready=0, all output fields are held stable and no channel is ready.
- In LOCK, if lock_chan deasserts in_valid, the lock is held and other channels wait. This is a bubble, not a release.
- MODE 1 may starve high-index channels. This is intended.
- CHANNELS not a power of two: the search wraps at CHANNELS-1 → 0. Indices ≥ CHANNELS are never produced.

## Timing
- Reset (async assert, sync-style deassert handled upstream):
  - out_valid=0, out_data=0, out_chan=0, out_last=0.
  - State ARB, lock_chan=0, ptr=CHANNELS-1, so channel 0 wins first in MODE 0.
- Latency is 1 cycle: a word accepted at edge k is visible on out_* after edge k.
- Throughput is 1 word/cycle sustained when out_ready=1. Simultaneous drain and refill in the same cycle is required (no bubble).
- Reset mid-packet drops the lock and the held word immediately. in_ready goes to 0 while rst_n=0.
- No combinational path from in_data to out_data. The only comb paths are in_valid/out_ready → in_ready.

## Test plan
- Single source: CHANNELS=4, MODE 0, only ch2 sends 0xA5A5_0001, in_last=1, out_ready=1 → next cycle out_valid=1, out_data=0xA5A5_0001, out_chan=2. out_valid=0 on the following cycle if there is no new input.
- Round-robin fairness: all 4 channels always valid, single-word packets, out_ready=1 from reset → out_chan sequence 0,1,2,3,0,1,… with one word per cycle and no gaps.
- Fixed priority: MODE 1, ch1 and ch3 continuously valid → out_chan=1 every cycle and in_ready[3] never asserts. Drop ch1 → out_chan=3 within 1 cycle.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=0x1234_5678 → out_* stable and all in_ready=0. Raise out_ready → the next word is loaded in the same edge.
- Packet lock: MODE 0, ch0 sends a 3-word packet (last on word 3) while ch1 is valid throughout. Insert a 1-cycle in_valid gap on ch0 → output is ch0,ch0,(bubble),ch0, then ch1. ch1 is never interleaved.
- Reset mid-operation: assert rst_n=0 in LOCK with out_valid=1 → out_valid=0 and out_data=0 without waiting for a clock edge. After release, ch0 wins first arbitration.
